aes_dec_wb_ctrl: RTL
====================

Name: aes_dec_wb_ctrl

Overview:
Wishbone-slave controller that sequences the decrypt_aes128 core from the management SoC. Software loads a 128-bit key and a 128-bit ciphertext through registers, then writes START. The block holds the core in reset, releases it, counts the core's fixed decrypt latency and captures the plaintext. It then raises done and an optional interrupt. It sits in user_project_wrapper between the wbs_* bus and the core.

Parameters:
BASE_ADDR, 32'h3000_0000, slave base; decode compares wbs_adr_i[31:8] to BASE_ADDR[31:8]
DEC_LATENCY, 11, cycles from core reset release until the core output is valid
RST_CYCLES, 2, cycles core_rst_o is held high at start of an operation
CNT_W, 5, counter width; must satisfy 2^CNT_W > max(DEC_LATENCY, RST_CYCLES)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
wbs_cyc_i  in  1  bus cycle
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_dat_o  out  32  read data
wbs_ack_o  out  1  acknowledge
core_rst_o  out  1  drives decReset of the core
core_key_o  out  128  drives key of the core
core_in_o  out  128  drives in (ciphertext) of the core
core_out_i  in  128  from out (plaintext) of the core
irq_o  out  1  level interrupt = done & irq_en

Behaviour:
- Reset (async, wb_rst_i=1):
  - State is IDLE.
  - key, cipher and plain registers = 0; irq_en=0; done=0.
  - core_rst_o=1; wbs_ack_o=0; wbs_dat_o=0; irq_o=0; counter=0.
- Register map, by byte offset. Word k maps to bits [32k+31:32k].
  - 0x00-0x0C: KEY0-3, R/W.
  - 0x10-0x1C: CT0-3, R/W.
  - 0x20: CTRL. Bit0 START is write-1, self-clearing, reads 0. Bit1 IRQ_EN is R/W.
  - 0x24: STATUS. Bit0 BUSY is read-only. Bit1 DONE is write-1-to-clear.
  - 0x28-0x34: PT0-3, read-only.
  - Other offsets inside the 256-byte window read 0 and ignore writes.
- Bus handshake:
  - A request is cyc&stb with a base match and ack low.
  - wbs_ack_o pulses high exactly one cycle after the request is sampled, and drops the following cycle.
  - Exactly one cycle of wait; no back-to-back acks.
  - wbs_dat_o is valid with ack and 0 otherwise.
  - An address outside the base window is never acked.
- Write rules:
  - KEY/CT writes honour wbs_sel_i per byte.
  - CTRL/STATUS act only when sel[0]=1.
  - KEY/CT writes while BUSY are acked and discarded.
  - START while BUSY is ignored.
- FSM:
  - IDLE: core_rst_o=1. START moves to LOAD and clears done.
  - LOAD: core_rst_o=1 for RST_CYCLES cycles; core_key_o/core_in_o are stable. Then go to RUN with counter=0.
  - RUN: core_rst_o=0. Counter increments each cycle. When counter==DEC_LATENCY-1, go to CAPTURE.
  - CAPTURE: one cycle. PT <= core_out_i, done <= 1. Next state is IDLE with core_rst_o=1.
- BUSY = state != IDLE.
- Total START-write-ack to DONE=1 is RST_CYCLES + DEC_LATENCY + 1 cycles.
- Simultaneous events:
  - CAPTURE setting done and a W1C to DONE in the same cycle: set wins.
  - START and DONE-clear in the same write: done cleared, operation starts.
- core_key_o/core_in_o are direct register outputs.
- PT holds its last captured value until the next CAPTURE.
- Reset mid-operation aborts immediately to the reset values. PT is zeroed.

Decomposition:
- Package aes_ctrl_pkg holds:
  - register offset localparams (OFF_KEY0 ... OFF_PT3);
  - the CTRL/STATUS bit indices;
  - the state enum type (IDLE, LOAD, RUN, CAPTURE).
- One sub-module aes_ctrl_wb_regs holds the Wishbone decode, the ack generation and the register file.
- The FSM and counter stay in the top module.

Test Plan:
- Reset:
  - Stimulus: assert wb_rst_i mid-RUN.
  - Response: core_rst_o=1, irq_o=0, STATUS reads 0x0, PT0 reads 0 after release.
- FIPS-197 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, CT 69c4e0d86a7b0430d8cdb78070b4c55a, START, core model returns 00112233445566778899aabbccddeeff.
  - Response: DONE after RST_CYCLES+DEC_LATENCY+1 cycles; PT3..PT0 = 00112233,44556677,8899aabb,ccddeeff.
- Interrupt:
  - Stimulus: IRQ_EN=1, run op, then write STATUS=0x2.
  - Response: irq_o rises with DONE and falls the cycle after the W1C ack.
- Busy protection:
  - Stimulus: write KEY0=0xdeadbeef and START during RUN.
  - Response: both acked; KEY0 keeps its old value; no restart; single DONE.
- Byte select:
  - Stimulus: KEY1=0, then write 0xaabbccdd with sel=4'b0101.
  - Response: KEY1 reads 0x00bb00dd.
- Bus edges:
  - Stimulus: address BASE+0x100, and a read of offset 0x40.
  - Response: first request is never acked; second is acked with data 0.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared offsets, bit indices, FSM state type and byte-merge helper
// Imported by aes_ctrl_wb_regs and aes_dec_wb_ctrl. Contains no ports.
package aes_ctrl_pkg;

  // Byte offsets inside the 256-byte slave window
  localparam logic [7:0] OFF_KEY0   = 8'h00;
  localparam logic [7:0] OFF_KEY1   = 8'h04;
  localparam logic [7:0] OFF_KEY2   = 8'h08;
  localparam logic [7:0] OFF_KEY3   = 8'h0C;
  localparam logic [7:0] OFF_CT0    = 8'h10;
  localparam logic [7:0] OFF_CT1    = 8'h14;
  localparam logic [7:0] OFF_CT2    = 8'h18;
  localparam logic [7:0] OFF_CT3    = 8'h1C;
  localparam logic [7:0] OFF_CTRL   = 8'h20;
  localparam logic [7:0] OFF_STATUS = 8'h24;
  localparam logic [7:0] OFF_PT0    = 8'h28;
  localparam logic [7:0] OFF_PT1    = 8'h2C;
  localparam logic [7:0] OFF_PT2    = 8'h30;
  localparam logic [7:0] OFF_PT3    = 8'h34;

  // CTRL / STATUS bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Merge new_w into old_w on the bytes whose select bit is set
  function automatic logic [31:0] apply_sel(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_ctrl_wb_regs.sv
// rtl/aes_ctrl_wb_regs.sv - Wishbone decode, single-wait ack and register file
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; wbs_* Wishbone slave;
//        busy/capture from the sequencer; core_out_i plaintext from the core;
//        key_o/ct_o register contents; start_o accepted START pulse; irq_en_o, done_o.
module aes_ctrl_wb_regs
  import aes_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic [31:0]  wbs_dat_o,
  output logic         wbs_ack_o,
  input  logic         busy,
  input  logic         capture,
  input  logic [127:0] core_out_i,
  output logic [127:0] key_o,
  output logic [127:0] ct_o,
  output logic         start_o,
  output logic         irq_en_o,
  output logic         done_o
);

  // Word addresses (byte offset / 4)
  localparam logic [5:0] W_KEY0   = OFF_KEY0[7:2];
  localparam logic [5:0] W_KEY1   = OFF_KEY1[7:2];
  localparam logic [5:0] W_KEY2   = OFF_KEY2[7:2];
  localparam logic [5:0] W_KEY3   = OFF_KEY3[7:2];
  localparam logic [5:0] W_CT0    = OFF_CT0[7:2];
  localparam logic [5:0] W_CT1    = OFF_CT1[7:2];
  localparam logic [5:0] W_CT2    = OFF_CT2[7:2];
  localparam logic [5:0] W_CT3    = OFF_CT3[7:2];
  localparam logic [5:0] W_CTRL   = OFF_CTRL[7:2];
  localparam logic [5:0] W_STATUS = OFF_STATUS[7:2];
  localparam logic [5:0] W_PT0    = OFF_PT0[7:2];
  localparam logic [5:0] W_PT1    = OFF_PT1[7:2];
  localparam logic [5:0] W_PT2    = OFF_PT2[7:2];
  localparam logic [5:0] W_PT3    = OFF_PT3[7:2];

  logic [3:0][31:0] key_q, ct_q, pt_q;
  logic             irq_en_q, done_q;
  logic             ack_q;
  logic             we_q;
  logic [3:0]       sel_q;
  logic [5:0]       off_q;
  logic [31:0]      wdat_q;
  logic [31:0]      rd_word;
  logic             req;
  logic             wr, wr_data, wr_ctrl, wr_stat, done_clr;
  logic             unused_adr_lsb;

  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  // Ack low is part of the request so an ack cycle can never start another
  assign req = wbs_cyc_i & wbs_stb_i & ~ack_q &
               (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

  // Writes commit on the edge that ends the ack cycle, from fields latched at request
  assign wr       = ack_q & we_q;
  assign wr_data  = wr & ~busy;
  assign wr_ctrl  = wr & (off_q == W_CTRL) & sel_q[0];
  assign wr_stat  = wr & (off_q == W_STATUS) & sel_q[0];
  assign start_o  = wr_ctrl & wdat_q[CTRL_START] & ~busy;
  assign done_clr = start_o | (wr_stat & wdat_q[STAT_DONE]);

  always_comb begin
    rd_word = '0;
    case (wbs_adr_i[7:2])
      W_KEY0:   rd_word = key_q[0];
      W_KEY1:   rd_word = key_q[1];
      W_KEY2:   rd_word = key_q[2];
      W_KEY3:   rd_word = key_q[3];
      W_CT0:    rd_word = ct_q[0];
      W_CT1:    rd_word = ct_q[1];
      W_CT2:    rd_word = ct_q[2];
      W_CT3:    rd_word = ct_q[3];
      W_CTRL:   rd_word[CTRL_IRQ_EN] = irq_en_q;
      W_STATUS: begin
        rd_word[STAT_BUSY] = busy;
        rd_word[STAT_DONE] = done_q;
      end
      W_PT0:    rd_word = pt_q[0];
      W_PT1:    rd_word = pt_q[1];
      W_PT2:    rd_word = pt_q[2];
      W_PT3:    rd_word = pt_q[3];
      default:  rd_word = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      wbs_dat_o <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      off_q     <= '0;
      wdat_q    <= '0;
      key_q     <= '0;
      ct_q      <= '0;
      pt_q      <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ack_q <= req;
      if (req) begin
        we_q      <= wbs_we_i;
        sel_q     <= wbs_sel_i;
        off_q     <= wbs_adr_i[7:2];
        wdat_q    <= wbs_dat_i;
        wbs_dat_o <= wbs_we_i ? 32'h0 : rd_word;
      end else begin
        wbs_dat_o <= '0;
      end

      for (int k = 0; k < 4; k++) begin
        if (wr_data && off_q == W_KEY0 + 6'(k))
          key_q[k] <= apply_sel(key_q[k], wdat_q, sel_q);
        if (wr_data && off_q == W_CT0 + 6'(k))
          ct_q[k] <= apply_sel(ct_q[k], wdat_q, sel_q);
      end

      if (wr_ctrl)
        irq_en_q <= wdat_q[CTRL_IRQ_EN];

      if (capture)
        pt_q <= core_out_i;

      // Capture setting DONE takes priority over any clear in the same cycle
      if (capture)
        done_q <= 1'b1;
      else if (done_clr)
        done_q <= 1'b0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign key_o     = key_q;
  assign ct_o      = ct_q;
  assign irq_en_o  = irq_en_q;
  assign done_o    = done_q;

endmodule

// File: rtl/aes_dec_wb_ctrl.sv
// rtl/aes_dec_wb_ctrl.sv - Wishbone sequencer for the decrypt_aes128 core
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; wbs_* Wishbone slave;
//        core_rst_o/core_key_o/core_in_o drive the core; core_out_i plaintext back;
//        irq_o level interrupt (done & irq_en).
module aes_dec_wb_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          DEC_LATENCY = 11,
  parameter int          RST_CYCLES  = 2,
  parameter int          CNT_W       = 5
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic [31:0]  wbs_dat_o,
  output logic         wbs_ack_o,
  output logic         core_rst_o,
  output logic [127:0] core_key_o,
  output logic [127:0] core_in_o,
  input  logic [127:0] core_out_i,
  output logic         irq_o
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEC_LAST = CNT_W'(DEC_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy, capture, start, irq_en, done;

  aes_ctrl_wb_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_ack_o  (wbs_ack_o),
    .busy       (busy),
    .capture    (capture),
    .core_out_i (core_out_i),
    .key_o      (core_key_o),
    .ct_o       (core_in_o),
    .start_o    (start),
    .irq_en_o   (irq_en),
    .done_o     (done)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter is reused: LOAD counts reset-hold cycles, RUN counts core latency
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cnt_q == RST_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (cnt_q == DEC_LAST) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_rst_o = 1'b1;
    capture    = 1'b0;
    case (state_q)
      RUN:     core_rst_o = 1'b0;
      CAPTURE: begin
        core_rst_o = 1'b0;
        capture    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign irq_o = done & irq_en;

endmodule
